// File: rtl/abc_instr_pkg.sv
// Shared definitions for the CoreABC instruction store: slice geometry helpers,
// fetch/APB state encodings and APB access-mode constants.
package abc_instr_pkg;

  localparam int APB_NONE = 0;
  localparam int APB_RO   = 1;
  localparam int APB_RW   = 2;

  typedef enum logic {
    F_IDLE,
    F_FETCH
  } fetch_state_e;

  typedef enum logic [1:0] {
    A_IDLE,
    A_WAIT,
    A_RD,
    A_DONE
  } apb_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int calc_nslices(input int iwidth, input int dwidth);
    return (iwidth + dwidth - 1) / dwidth;
  endfunction

  // A single-slice instruction still gets one slice-index bit so {instr,slice} stays uniform
  function automatic int calc_slw(input int nslices);
    int w;
    w = clog2(nslices);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/abc_instr_store_if.sv
// APB slave bus for run-time access to the instruction store.
interface abc_instr_store_if #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 8
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [AWIDTH-1:0] PADDR;
  logic [DWIDTH-1:0] PWDATA;
  logic [DWIDTH-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/abc_instr_ram.sv
// Single-port synchronous RAM holding instruction slices; one-cycle registered read.
module abc_instr_ram #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 11,
  parameter int DEPTH  = 2048
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rdata_q;
  logic              in_range;

  // Indices past DEPTH have no storage: writes are dropped and reads return zero
  assign in_range = int'(addr_i) < DEPTH;

  always_ff @(posedge clk_i) begin
    if (we_i && in_range) mem_q[addr_i] <= wdata_i;
    rdata_q <= in_range ? mem_q[addr_i] : '0;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/abc_instr_store.sv
// CoreABC instruction store: fetch FSM assembles one instruction per START from RAM
// slices while stalling the core; an APB slave reads/writes the store between fetches.
module abc_instr_store
  import abc_instr_pkg::*;
#(
  parameter int AWIDTH          = 12,
  parameter int DWIDTH          = 8,
  parameter int ICWIDTH         = 8,
  parameter int ICDEPTH         = 256,
  parameter int IWWIDTH         = 58,
  parameter int IMEM_APB_ACCESS = 2
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               START,
  input  logic [ICWIDTH-1:0] ADDRESS,
  output logic               STALL,
  output logic [IWWIDTH-1:0] INSTRUCTION,
  abc_instr_store_if.slave   apb
);

  localparam int NSLICES = calc_nslices(IWWIDTH, DWIDTH);
  localparam int SLW     = calc_slw(NSLICES);
  localparam int RAW     = ICWIDTH + SLW;
  localparam int TOPW    = IWWIDTH - (NSLICES - 1) * DWIDTH;
  localparam logic [DWIDTH-1:0] TOP_MASK = {DWIDTH{1'b1}} >> (DWIDTH - TOPW);
  localparam logic [SLW:0]      CNT_LAST = (SLW + 1)'(NSLICES);

  fetch_state_e                 fstate_q, fstate_d;
  logic [ICWIDTH-1:0]           faddr_q, faddr_d;
  logic [SLW:0]                 cnt_q, cnt_d;
  logic [NSLICES*DWIDTH-1:0]    shadow_q, shadow_d;
  logic [IWWIDTH-1:0]           instr_q, instr_d;
  logic                         fetch_ram;
  logic [RAW-1:0]               fetch_addr;

  apb_state_e                   astate_q, astate_d;
  logic                         apb_access, apb_err, grant_ok, try_grant;
  logic                         apb_we, pready, pslverr;
  logic [ICWIDTH-1:0]           p_instr;
  logic [SLW-1:0]               p_slice;
  logic                         unused_paddr;

  logic                         ram_we;
  logic [RAW-1:0]               ram_addr;
  logic [DWIDTH-1:0]            ram_wdata, ram_rdata;

  // Fetch: slice k is addressed in cycle T+k and lands in the shadow one cycle later
  always_comb begin
    fstate_d   = fstate_q;
    faddr_d    = faddr_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    instr_d    = instr_q;
    STALL      = 1'b0;
    fetch_ram  = 1'b0;
    fetch_addr = {ADDRESS, {SLW{1'b0}}};
    case (fstate_q)
      F_IDLE: begin
        if (START) begin
          STALL     = 1'b1;
          fetch_ram = 1'b1;
          faddr_d   = ADDRESS;
          cnt_d     = (SLW + 1)'(1);
          fstate_d  = F_FETCH;
        end
      end
      F_FETCH: begin
        STALL = 1'b1;
        for (int k = 0; k < NSLICES; k++) begin
          if (int'(cnt_q) == k + 1) shadow_d[k*DWIDTH +: DWIDTH] = ram_rdata;
        end
        if (cnt_q == CNT_LAST) begin
          instr_d  = shadow_d[IWWIDTH-1:0];
          cnt_d    = '0;
          fstate_d = F_IDLE;
        end else begin
          fetch_ram  = 1'b1;
          fetch_addr = {faddr_q, cnt_q[SLW-1:0]};
          cnt_d      = cnt_q + 1'b1;
        end
      end
      default: fstate_d = F_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      fstate_q <= F_IDLE;
      faddr_q  <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      instr_q  <= '0;
    end else begin
      fstate_q <= fstate_d;
      faddr_q  <= faddr_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      instr_q  <= instr_d;
    end
  end

  assign INSTRUCTION  = instr_q;
  assign apb_access   = apb.PSEL & apb.PENABLE;
  assign p_instr      = apb.PADDR[SLW +: ICWIDTH];
  assign p_slice      = apb.PADDR[SLW-1:0];
  assign unused_paddr = ^apb.PADDR;
  assign apb_err      = (IMEM_APB_ACCESS == APB_NONE)
                      | (apb.PWRITE & (IMEM_APB_ACCESS == APB_RO))
                      | (int'(p_instr) >= ICDEPTH)
                      | (int'(p_slice) >= NSLICES);
  // Fetches own the RAM: APB only gets it when no fetch is running or starting
  assign grant_ok     = (fstate_q == F_IDLE) & ~START;

  always_comb begin
    astate_d  = astate_q;
    pready    = 1'b0;
    pslverr   = 1'b0;
    apb_we    = 1'b0;
    try_grant = 1'b0;
    case (astate_q)
      A_IDLE: begin
        if (apb_access) begin
          if (apb_err) begin
            pready   = 1'b1;
            pslverr  = 1'b1;
            astate_d = A_DONE;
          end else begin
            try_grant = 1'b1;
            astate_d  = A_WAIT;
          end
        end
      end
      A_WAIT: begin
        if (!apb.PSEL) astate_d = A_IDLE;
        else           try_grant = 1'b1;
      end
      A_RD: begin
        if (!apb.PSEL) begin
          astate_d = A_IDLE;
        end else begin
          pready   = 1'b1;
          astate_d = A_DONE;
        end
      end
      A_DONE:  astate_d = A_IDLE;
      default: astate_d = A_IDLE;
    endcase
    if (try_grant && grant_ok) begin
      if (apb.PWRITE) begin
        apb_we   = 1'b1;
        pready   = 1'b1;
        astate_d = A_DONE;
      end else begin
        astate_d = A_RD;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) astate_q <= A_IDLE;
    else       astate_q <= astate_d;
  end

  assign apb.PREADY  = pready;
  assign apb.PSLVERR = pslverr;
  assign apb.PRDATA  = (astate_q == A_RD) ? ram_rdata : '0;

  // Top slice keeps only the bits that exist in the instruction word
  assign ram_we    = apb_we;
  assign ram_addr  = fetch_ram ? fetch_addr : {p_instr, p_slice};
  assign ram_wdata = (int'(p_slice) == NSLICES - 1) ? (apb.PWDATA & TOP_MASK) : apb.PWDATA;

  abc_instr_ram #(
    .DWIDTH (DWIDTH),
    .AWIDTH (RAW),
    .DEPTH  (ICDEPTH * (2 ** SLW))
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_abc_instr_store.sv
// Scoreboard bench for abc_instr_store: a read/write instance plus a read-only,
// 200-deep instance for the error paths.
module tb_abc_instr_store;

  localparam int TOPW = 58 - 7 * 8;
  localparam logic [7:0] TOP_MASK = 8'((1 << TOPW) - 1);

  logic        clk;
  logic        rstn;
  logic        start;
  logic [7:0]  address;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [7:0]  pwdata;
  bit          target;

  logic        stallA, stallB;
  logic [57:0] instrA, instrB;

  int total;
  int bad;

  logic [7:0]  modelMem [0:255][0:7];
  logic [57:0] expInstrQ[$];
  logic [7:0]  expRdQ[$];
  logic [57:0] expI;
  logic [7:0]  expR;
  time         stallFallTime;
  time         readyTime;

  abc_instr_store_if #(.AWIDTH(12), .DWIDTH(8)) apbA ();
  abc_instr_store_if #(.AWIDTH(12), .DWIDTH(8)) apbB ();

  assign apbA.PSEL    = psel & ~target;
  assign apbB.PSEL    = psel & target;
  assign apbA.PENABLE = penable;
  assign apbB.PENABLE = penable;
  assign apbA.PWRITE  = pwrite;
  assign apbB.PWRITE  = pwrite;
  assign apbA.PADDR   = paddr;
  assign apbB.PADDR   = paddr;
  assign apbA.PWDATA  = pwdata;
  assign apbB.PWDATA  = pwdata;

  wire [7:0] prdata  = target ? apbB.PRDATA  : apbA.PRDATA;
  wire       pready  = target ? apbB.PREADY  : apbA.PREADY;
  wire       pslverr = target ? apbB.PSLVERR : apbA.PSLVERR;

  abc_instr_store dutA (
    .CLK         (clk),
    .RSTN        (rstn),
    .START       (start),
    .ADDRESS     (address),
    .STALL       (stallA),
    .INSTRUCTION (instrA),
    .apb         (apbA)
  );

  abc_instr_store #(.ICDEPTH(200), .IMEM_APB_ACCESS(1)) dutB (
    .CLK         (clk),
    .RSTN        (rstn),
    .START       (1'b0),
    .ADDRESS     (8'd0),
    .STALL       (stallB),
    .INSTRUCTION (instrB),
    .apb         (apbB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [57:0] expInstr(input int idx);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[k*8 +: 8] = modelMem[idx][k];
    return v[57:0];
  endfunction

  function automatic void modelWrite(input int idx, input int sl, input logic [7:0] d);
    modelMem[idx][sl] = (sl == 7) ? (d & TOP_MASK) : d;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apbAccess(input bit tgt, input bit wr, input logic [7:0] idx, input logic [2:0] sl,
                           input logic [7:0] wdata, output logic [7:0] rdata, output logic err,
                           output int waits);
    bit ok;
    ok    = 1'b0;
    waits = 0;
    rdata = '0;
    err   = 1'b0;
    stepCycle();
    target  = tgt;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = {1'b0, idx, sl};
    pwdata  = wdata;
    stepCycle();
    penable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pready === 1'b1) begin
        rdata     = prdata;
        err       = pslverr;
        readyTime = $time;
        ok        = 1'b1;
        break;
      end
      waits++;
      stepCycle();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL apb_timeout: PREADY never rose, waited %0d cycles, required < 40", waits);
    end
    stepCycle();
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  task automatic doFetch(input logic [7:0] a, output int stallCycles, output logic [57:0] lastStallInstr);
    bit ok;
    ok = 1'b0;
    stallCycles = 0;
    lastStallInstr = 'x;
    stepCycle();
    start   = 1'b1;
    address = a;
    @(negedge clk);
    if (stallA === 1'b1) begin
      stallCycles++;
      lastStallInstr = instrA;
    end
    stepCycle();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stallA === 1'b1) begin
        stallCycles++;
        lastStallInstr = instrA;
      end else begin
        ok = 1'b1;
        stallFallTime = $time;
        break;
      end
      stepCycle();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL fetch_timeout: STALL stuck high after %0d cycles", stallCycles);
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (stallA !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall: got %b want 0", stallA); end
    total++;
    if (instrA !== 58'd0) begin bad++; $display("[TB] FAIL reset_instr: got %h want 0", instrA); end
    total++;
    if (apbA.PRDATA !== 8'd0) begin bad++; $display("[TB] FAIL reset_prdata: got %h want 00", apbA.PRDATA); end
    total++;
    if (apbA.PREADY !== 1'b0) begin bad++; $display("[TB] FAIL reset_pready: got %b want 0", apbA.PREADY); end
    total++;
    if (apbA.PSLVERR !== 1'b0) begin bad++; $display("[TB] FAIL reset_pslverr: got %b want 0", apbA.PSLVERR); end
    stepCycle();
    rstn = 1'b1;
  endtask

  task automatic test_write_fetch();
    logic [7:0]  wrData [8];
    logic [7:0]  rd;
    logic        err;
    int          waits, stalls;
    logic [57:0] held;
    wrData = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFF};
    for (int k = 0; k < 8; k++) begin
      apbAccess(1'b0, 1'b1, 8'd5, 3'(k), wrData[k], rd, err, waits);
      modelWrite(5, k, wrData[k]);
      total++;
      if (err !== 1'b0 || waits != 0) begin
        bad++;
        $display("[TB] FAIL write_slice%0d: err=%b waits=%0d want err=0 waits=0", k, err, waits);
      end
    end
    expInstrQ.push_back(58'h3DCBA9876543210);
    doFetch(8'd5, stalls, held);
    expI = expInstrQ.pop_front();
    total++;
    if (stalls != 9) begin bad++; $display("[TB] FAIL fetch1_stall_len: got %0d want 9", stalls); end
    total++;
    if (held !== 58'd0) begin bad++; $display("[TB] FAIL fetch1_hold: got %h want 0", held); end
    total++;
    if (instrA !== expI) begin bad++; $display("[TB] FAIL fetch1_instr: got %h want %h", instrA, expI); end
    expRdQ.push_back(8'h03);
    apbAccess(1'b0, 1'b0, 8'd5, 3'd7, 8'h00, rd, err, waits);
    expR = expRdQ.pop_front();
    total++;
    if (rd !== expR || err !== 1'b0 || waits != 1) begin
      bad++;
      $display("[TB] FAIL read_top_slice: data=%h err=%b waits=%0d want data=%h err=0 waits=1", rd, err, waits, expR);
    end
  endtask

  task automatic test_read_during_fetch();
    logic [7:0]  rd;
    logic        err;
    int          waits, stalls;
    logic [57:0] held;
    expInstrQ.push_back(expInstr(5));
    expRdQ.push_back(modelMem[5][2]);
    fork
      doFetch(8'd5, stalls, held);
      begin
        stepCycle();
        apbAccess(1'b0, 1'b0, 8'd5, 3'd2, 8'h00, rd, err, waits);
      end
    join
    expI = expInstrQ.pop_front();
    expR = expRdQ.pop_front();
    total++;
    if (instrA !== expI || stalls != 9) begin
      bad++;
      $display("[TB] FAIL fetch2_instr: got %h stalls=%0d want %h stalls=9", instrA, stalls, expI);
    end
    total++;
    if (rd !== expR || err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL read_in_fetch_data: data=%h err=%b want data=%h err=0", rd, err, expR);
    end
    total++;
    if (readyTime != stallFallTime + 10) begin
      bad++;
      $display("[TB] FAIL read_in_fetch_timing: PREADY at %0t want %0t", readyTime, stallFallTime + 10);
    end
  endtask

  task automatic test_fetch_write_collision();
    int          offset, stalls;
    logic [57:0] held;
    bit          seen;
    seen   = 1'b0;
    offset = 0;
    stepCycle();
    target  = 1'b0;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = {1'b0, 8'd5, 3'd0};
    pwdata  = 8'hA5;
    stepCycle();
    penable = 1'b1;
    start   = 1'b1;
    address = 8'd5;
    expInstrQ.push_back(expInstr(5));
    @(negedge clk);
    total++;
    if (pready !== 1'b0 || stallA !== 1'b1) begin
      bad++;
      $display("[TB] FAIL collide_start: PREADY=%b STALL=%b want PREADY=0 STALL=1", pready, stallA);
    end
    stepCycle();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pready === 1'b1) begin
        offset = i + 1;
        seen   = 1'b1;
        break;
      end
      stepCycle();
    end
    expI = expInstrQ.pop_front();
    total++;
    if (!seen || offset != 9 || stallA !== 1'b0) begin
      bad++;
      $display("[TB] FAIL collide_write_delay: PREADY offset=%0d STALL=%b want offset=9 STALL=0", offset, stallA);
    end
    total++;
    if (instrA !== expI) begin bad++; $display("[TB] FAIL collide_old_data: got %h want %h", instrA, expI); end
    stepCycle();
    psel    = 1'b0;
    penable = 1'b0;
    modelWrite(5, 0, 8'hA5);
    expInstrQ.push_back(expInstr(5));
    doFetch(8'd5, stalls, held);
    expI = expInstrQ.pop_front();
    total++;
    if (instrA !== expI) begin bad++; $display("[TB] FAIL collide_new_data: got %h want %h", instrA, expI); end
  endtask

  task automatic test_readonly_errors();
    logic [7:0] rd;
    logic       err;
    int         waits;
    apbAccess(1'b1, 1'b1, 8'd5, 3'd0, 8'h77, rd, err, waits);
    total++;
    if (err !== 1'b1 || waits != 0) begin
      bad++;
      $display("[TB] FAIL ro_write_err: err=%b waits=%0d want err=1 waits=0", err, waits);
    end
    apbAccess(1'b1, 1'b0, 8'd200, 3'd0, 8'h00, rd, err, waits);
    total++;
    if (err !== 1'b1 || rd !== 8'h00 || waits != 0) begin
      bad++;
      $display("[TB] FAIL depth_read_err: err=%b data=%h waits=%0d want err=1 data=00 waits=0", err, rd, waits);
    end
    apbAccess(1'b1, 1'b0, 8'd199, 3'd7, 8'h00, rd, err, waits);
    total++;
    if (err !== 1'b0 || waits != 1) begin
      bad++;
      $display("[TB] FAIL depth_last_ok: err=%b waits=%0d want err=0 waits=1", err, waits);
    end
    target = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    int          stalls;
    logic [57:0] held;
    stepCycle();
    start   = 1'b1;
    address = 8'd5;
    stepCycle();
    start = 1'b0;
    stepCycle();
    stepCycle();
    rstn = 1'b0;
    #1;
    total++;
    if (stallA !== 1'b0 || instrA !== 58'd0) begin
      bad++;
      $display("[TB] FAIL abort_reset: STALL=%b INSTR=%h want STALL=0 INSTR=0", stallA, instrA);
    end
    stepCycle();
    rstn = 1'b1;
    expInstrQ.push_back(expInstr(5));
    doFetch(8'd5, stalls, held);
    expI = expInstrQ.pop_front();
    total++;
    if (instrA !== expI || stalls != 9 || held !== 58'd0) begin
      bad++;
      $display("[TB] FAIL after_reset_fetch: got %h stalls=%0d held=%h want %h stalls=9 held=0", instrA, stalls, held, expI);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    logic       err;
    int         waits, c1, c2;
    bit         done;
    for (int k = 0; k < 8; k++) begin
      apbAccess(1'b0, 1'b1, 8'd6, 3'(k), 8'hA0 + 8'(k), rd, err, waits);
      modelWrite(6, k, 8'hA0 + 8'(k));
    end
    expInstrQ.push_back(expInstr(5));
    expInstrQ.push_back(expInstr(6));
    c1 = 0;
    stepCycle();
    start   = 1'b1;
    address = 8'd5;
    @(negedge clk);
    if (stallA === 1'b1) c1++;
    for (int k = 1; k <= 8; k++) begin
      stepCycle();
      start   = (k == 4);
      address = (k == 4) ? 8'd9 : 8'd5;
      @(negedge clk);
      if (stallA === 1'b1) c1++;
    end
    stepCycle();
    start   = 1'b1;
    address = 8'd6;
    @(negedge clk);
    expI = expInstrQ.pop_front();
    total++;
    if (c1 != 9 || stallA !== 1'b1) begin
      bad++;
      $display("[TB] FAIL b2b_first_stall: stalls=%0d STALL=%b want 9 and 1", c1, stallA);
    end
    total++;
    if (instrA !== expI) begin bad++; $display("[TB] FAIL b2b_first_instr: got %h want %h", instrA, expI); end
    c2   = 1;
    done = 1'b0;
    stepCycle();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stallA === 1'b1) c2++;
      else begin
        done = 1'b1;
        break;
      end
      stepCycle();
    end
    expI = expInstrQ.pop_front();
    total++;
    if (!done || c2 != 9) begin
      bad++;
      $display("[TB] FAIL b2b_second_stall: stalls=%0d done=%b want 9 and 1", c2, done);
    end
    total++;
    if (instrA !== expI) begin bad++; $display("[TB] FAIL b2b_second_instr: got %h want %h", instrA, expI); end
  endtask

  task automatic test_idle_instance();
    @(negedge clk);
    total++;
    if (stallB !== 1'b0 || instrB !== 58'd0) begin
      bad++;
      $display("[TB] FAIL idle_instance: STALL=%b INSTR=%h want 0 and 0", stallB, instrB);
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rstn    = 1'b0;
    start   = 1'b0;
    address = '0;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    target  = 1'b0;
    stallFallTime = 0;
    readyTime     = 0;
    test_reset();
    test_write_fetch();
    test_read_during_fetch();
    test_fetch_write_collision();
    test_readonly_errors();
    test_reset_mid_fetch();
    test_back_to_back();
    test_idle_instance();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
